// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one OBI memory port between the instruction and data hosts and
// routes each response to its issuer. Define LUCID_ARB_ROUND_ROBIN_EN for round-robin selection.
module obi_mem_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic        RESET_OWNER     = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // instruction host
   input  logic        imem_req_i,
   input  logic [63:0] imem_addr_i,
   output logic        imem_gnt_o,
   output logic        imem_rvalid_o,
   output logic [31:0] imem_rdata_o,
   // data host
   input  logic        dmem_req_i,
   input  logic        dmem_we_i,
   input  logic [7:0]  dmem_be_i,
   input  logic [63:0] dmem_addr_i,
   input  logic [63:0] dmem_wdata_i,
   output logic        dmem_gnt_o,
   output logic        dmem_rvalid_o,
   output logic [63:0] dmem_rdata_o,
   // shared memory port
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [7:0]  mem_be_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [63:0] mem_rdata_i,
   output logic        err_o
);

   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic OWNER_D = 1'b1;
   localparam logic OWNER_I = 1'b0;

   logic             r_fifo_owner [MAX_OUTSTANDING];
   logic             r_fifo_half  [MAX_OUTSTANDING];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_lock;
   logic             r_lock_owner;
   logic             r_err;

   logic             w_full;
   logic             w_empty;
   logic             w_pref_owner;
   logic             w_sel_owner;
   logic             w_sel_req;
   logic             w_mem_req;
   logic [63:0]      w_sel_addr;
   logic             w_push;
   logic             w_pop;
   logic             w_head_owner;
   logic             w_head_half;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_empty = (r_count == '0);

`ifdef LUCID_ARB_ROUND_ROBIN_EN
   logic r_last_owner;
   logic r_granted;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last_owner <= RESET_OWNER;
         r_granted    <= 1'b0;
      end else if (w_push) begin
         r_last_owner <= w_sel_owner;
         r_granted    <= 1'b1;
      end
   end

   // Before the first grant the reset owner is favoured; afterwards the other host is.
   assign w_pref_owner = r_granted ? ~r_last_owner : RESET_OWNER;
`else
   logic w_unused_reset_owner;

   assign w_pref_owner         = OWNER_D;
   assign w_unused_reset_owner = RESET_OWNER;
`endif

   // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_sel_owner = OWNER_D;
      if (r_lock) begin
         w_sel_owner = r_lock_owner;
      end else if (dmem_req_i && imem_req_i) begin
         w_sel_owner = w_pref_owner;
      end else if (dmem_req_i) begin
         w_sel_owner = OWNER_D;
      end else if (imem_req_i) begin
         w_sel_owner = OWNER_I;
      end
   end

   assign w_sel_req  = (w_sel_owner == OWNER_D) ? dmem_req_i : imem_req_i;
   assign w_sel_addr = (w_sel_owner == OWNER_D) ? dmem_addr_i : imem_addr_i;
   // Full is taken from the registered count, so rvalid never reaches mem_req_o.
   assign w_mem_req  = w_sel_req && !w_full;
   assign w_push     = w_mem_req && mem_gnt_i;
   assign w_pop      = mem_rvalid_i && !w_empty;

   assign w_head_owner = r_fifo_owner[r_rd_ptr];
   assign w_head_half  = r_fifo_half[r_rd_ptr];

   // Shared port; everything is forced to zero while reset is asserted.
   assign mem_req_o   = rst_ni && w_mem_req;
   assign mem_we_o    = rst_ni && (w_sel_owner == OWNER_D) && dmem_we_i;
   assign mem_be_o    = !rst_ni ? 8'h00 : ((w_sel_owner == OWNER_D) ? dmem_be_i : 8'hFF);
   assign mem_addr_o  = rst_ni ? w_sel_addr : 64'h0;
   assign mem_wdata_o = (rst_ni && (w_sel_owner == OWNER_D)) ? dmem_wdata_i : 64'h0;

   assign imem_gnt_o = rst_ni && w_push && (w_sel_owner == OWNER_I);
   assign dmem_gnt_o = rst_ni && w_push && (w_sel_owner == OWNER_D);

   assign imem_rvalid_o = rst_ni && w_pop && (w_head_owner == OWNER_I);
   assign dmem_rvalid_o = rst_ni && w_pop && (w_head_owner == OWNER_D);
   assign imem_rdata_o  = !rst_ni ? 32'h0 : (w_head_half ? mem_rdata_i[63:32] : mem_rdata_i[31:0]);
   assign dmem_rdata_o  = rst_ni ? mem_rdata_i : 64'h0;

   assign err_o = r_err;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // NOTE: entry storage is not reset; r_count alone decides which entries are valid.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_owner[r_wr_ptr] <= w_sel_owner;
         r_fifo_half[r_wr_ptr]  <= w_sel_addr[2];
      end
   end

   // Lock holds an ungranted request on the same host until it is granted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lock       <= 1'b0;
         r_lock_owner <= OWNER_D;
      end else if (w_mem_req && !mem_gnt_i) begin
         r_lock       <= 1'b1;
         r_lock_owner <= w_sel_owner;
      end else if (w_push) begin
         r_lock       <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if (mem_rvalid_i && w_empty) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: directed bench with an ownership scoreboard for obi_mem_arbiter.
// Expected round-robin behaviour follows LUCID_ARB_ROUND_ROBIN_EN.
module tb_obi_mem_arbiter;

   logic        clk_i;
   logic        rst_ni;
   logic        imem_req_i;
   logic [63:0] imem_addr_i;
   logic        imem_gnt_o;
   logic        imem_rvalid_o;
   logic [31:0] imem_rdata_o;
   logic        dmem_req_i;
   logic        dmem_we_i;
   logic [7:0]  dmem_be_i;
   logic [63:0] dmem_addr_i;
   logic [63:0] dmem_wdata_i;
   logic        dmem_gnt_o;
   logic        dmem_rvalid_o;
   logic [63:0] dmem_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [7:0]  mem_be_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [63:0] mem_rdata_i;
   logic        err_o;

   typedef struct packed {
      logic owner;   // 1 = data host, 0 = instruction host
      logic half;    // addr[2] of the issuing request
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_mis = 0;
   logic exp_own;

   obi_mem_arbiter dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .imem_req_i   (imem_req_i),
      .imem_addr_i  (imem_addr_i),
      .imem_gnt_o   (imem_gnt_o),
      .imem_rvalid_o(imem_rvalid_o),
      .imem_rdata_o (imem_rdata_o),
      .dmem_req_i   (dmem_req_i),
      .dmem_we_i    (dmem_we_i),
      .dmem_be_i    (dmem_be_i),
      .dmem_addr_i  (dmem_addr_i),
      .dmem_wdata_i (dmem_wdata_i),
      .dmem_gnt_o   (dmem_gnt_o),
      .dmem_rvalid_o(dmem_rvalid_o),
      .dmem_rdata_o (dmem_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .err_o        (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      @(negedge clk_i);
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      imem_req_i   = 1'b0;
      imem_addr_i  = 64'h0;
      dmem_req_i   = 1'b0;
      dmem_we_i    = 1'b0;
      dmem_be_i    = 8'h00;
      dmem_addr_i  = 64'h0;
      dmem_wdata_i = 64'h0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 64'h0;
   endtask

   task automatic push_exp(input logic owner, input logic half);
      exp_t e;
      e.owner = owner;
      e.half  = half;
      exp_q.push_back(e);
   endtask

   // Pops the oldest expected owner and checks the routing of the rdata currently driven.
   task automatic chk_resp(input logic [63:0] rd);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_mis++;
         $error("FAIL sb_empty: observed response expected none");
         return;
      end
      e = exp_q.pop_front();
      if (e.owner) begin
         chk("d_rvalid", dmem_rvalid_o, 1);
         chk("i_rvalid_quiet", imem_rvalid_o, 0);
         chk("d_rdata", dmem_rdata_o, rd);
      end else begin
         chk("i_rvalid", imem_rvalid_o, 1);
         chk("d_rvalid_quiet", dmem_rvalid_o, 0);
         chk("i_rdata", imem_rdata_o, e.half ? {32'h0, rd[63:32]} : {32'h0, rd[31:0]});
      end
   endtask

   initial begin
      // reset with every input active
      rst_ni       = 1'b0;
      idle();
      imem_req_i   = 1'b1;
      imem_addr_i  = 64'h1234;
      dmem_req_i   = 1'b1;
      dmem_addr_i  = 64'h5678;
      dmem_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'hAAAA_BBBB_CCCC_DDDD;
      settle();
      chk("rst_req", mem_req_o, 0);
      chk("rst_ig<nt", imem_gnt_o, 0);
      chk("rst_dgnt", dmem_gnt_o, 0);
      chk("rst_irv", imem_rvalid_o, 0);
      chk("rst_drv", dmem_rvalid_o, 0);
      chk("rst_addr", mem_addr_o, 64'h0);
      chk("rst_wdata", mem_wdata_o, 64'h0);
      chk("rst_err", err_o, 0);
      cycle();
      idle();
      rst_ni = 1'b1;
      cycle();

      // instruction-only read, upper half
      imem_req_i  = 1'b1;
      imem_addr_i = 64'h8000_0004;
      mem_gnt_i   = 1'b1;
      settle();
      chk("t1_req", mem_req_o, 1);
      chk("t1_ignt", imem_gnt_o, 1);
      chk("t1_dgnt", dmem_gnt_o, 0);
      chk("t1_addr", mem_addr_o, 64'h8000_0004);
      chk("t1_be", mem_be_o, 8'hFF);
      chk("t1_we", mem_we_o, 0);
      chk("t1_wdata", mem_wdata_o, 64'h0);
      push_exp(1'b0, 1'b1);
      cycle();
      imem_req_i   = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h1122_3344_5566_7788;
      settle();
      chk_resp(mem_rdata_i);
      chk("t1_rdata_const", imem_rdata_o, 32'h1122_3344);
      cycle();
      mem_rvalid_i = 1'b0;

      // both hosts request, grant withheld three cycles
      imem_req_i   = 1'b1;
      imem_addr_i  = 64'h1000;
      dmem_req_i   = 1'b1;
      dmem_we_i    = 1'b1;
      dmem_be_i    = 8'h0F;
      dmem_addr_i  = 64'h2000_0008;
      dmem_wdata_i = 64'hDEAD_BEEF_0BAD_F00D;
      mem_gnt_i    = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("t2_hold_addr", mem_addr_o, 64'h2000_0008);
         chk("t2_hold_req", mem_req_o, 1);
         chk("t2_hold_dgnt", dmem_gnt_o, 0);
         chk("t2_hold_ignt", imem_gnt_o, 0);
         cycle();
      end
      mem_gnt_i = 1'b1;
      settle();
      chk("t2_addr", mem_addr_o, 64'h2000_0008);
      chk("t2_dgnt", dmem_gnt_o, 1);
      chk("t2_ignt", imem_gnt_o, 0);
      chk("t2_we", mem_we_o, 1);
      chk("t2_be", mem_be_o, 8'h0F);
      chk("t2_wdata", mem_wdata_o, 64'hDEAD_BEEF_0BAD_F00D);
      push_exp(1'b1, 1'b0);
      cycle();
      dmem_req_i = 1'b0;
      dmem_we_i  = 1'b0;
      settle();
      chk("t2_ignt_next", imem_gnt_o, 1);
      chk("t2_iaddr", mem_addr_o, 64'h1000);
      chk("t2_iwe", mem_we_o, 0);
      push_exp(1'b0, 1'b0);
      cycle();

      // FIFO full: third request held off, also during the popping cycle
      settle();
      chk("t3_full_req", mem_req_o, 0);
      chk("t3_full_ignt", imem_gnt_o, 0);
      cycle();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'hAAAA_0001_BBBB_0002;
      settle();
      chk("t3_pop_req", mem_req_o, 0);
      chk_resp(mem_rdata_i);
      cycle();
      mem_rdata_i = 64'hCCCC_0003_DDDD_0004;
      settle();
      chk("t3_resume_req", mem_req_o, 1);
      chk("t3_resume_ignt", imem_gnt_o, 1);
      chk_resp(mem_rdata_i);
      push_exp(1'b0, 1'b0);
      cycle();
      imem_req_i  = 1'b0;
      mem_gnt_i   = 1'b0;
      mem_rdata_i = 64'h5555_6666_7777_8888;
      settle();
      chk_resp(mem_rdata_i);
      cycle();
      mem_rvalid_i = 1'b0;

      // I, D, I back-to-back with responses on three consecutive cycles
      imem_req_i  = 1'b1;
      imem_addr_i = 64'h104;
      mem_gnt_i   = 1'b1;
      settle();
      chk("t4_ignt0", imem_gnt_o, 1);
      push_exp(1'b0, 1'b1);
      cycle();
      imem_req_i   = 1'b0;
      dmem_req_i   = 1'b1;
      dmem_addr_i  = 64'h3000;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'hA0A0_A1A1_A2A2_A3A3;
      settle();
      chk("t4_dgnt", dmem_gnt_o, 1);
      chk_resp(mem_rdata_i);
      push_exp(1'b1, 1'b0);
      cycle();
      dmem_req_i  = 1'b0;
      imem_req_i  = 1'b1;
      imem_addr_i = 64'h200;
      mem_rdata_i = 64'hB0B0_B1B1_B2B2_B3B3;
      settle();
      chk("t4_ignt1", imem_gnt_o, 1);
      chk_resp(mem_rdata_i);
      push_exp(1'b0, 1'b0);
      cycle();
      imem_req_i  = 1'b0;
      mem_gnt_i   = 1'b0;
      mem_rdata_i = 64'hC0C0_C1C1_C2C2_C3C3;
      settle();
      chk_resp(mem_rdata_i);
      cycle();
      mem_rvalid_i = 1'b0;
      settle();
      chk("t4_err", err_o, 0);
      cycle();

      // reset mid-cycle with one outstanding, then a stray rvalid
      imem_req_i  = 1'b1;
      imem_addr_i = 64'h40;
      mem_gnt_i   = 1'b1;
      settle();
      chk("t5_ignt", imem_gnt_o, 1);
      push_exp(1'b0, 1'b0);
      cycle();
      dmem_req_i   = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h9999_8888_7777_6666;
      #3;
      rst_ni = 1'b0;
      #1;
      chk("t5_rst_req", mem_req_o, 0);
      chk("t5_rst_ignt", imem_gnt_o, 0);
      chk("t5_rst_dgnt", dmem_gnt_o, 0);
      chk("t5_rst_irv", imem_rvalid_o, 0);
      chk("t5_rst_drv", dmem_rvalid_o, 0);
      chk("t5_rst_addr", mem_addr_o, 64'h0);
      chk("t5_rst_irdata", imem_rdata_o, 32'h0);
      chk("t5_rst_drdata", dmem_rdata_o, 64'h0);
      exp_q.delete();
      cycle();
      idle();
      rst_ni = 1'b1;
      settle();
      chk("t5_err_clear", err_o, 0);
      cycle();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h1357_9BDF_2468_ACE0;
      settle();
      chk("t5_stray_irv", imem_rvalid_o, 0);
      chk("t5_stray_drv", dmem_rvalid_o, 0);
      cycle();
      mem_rvalid_i = 1'b0;
      settle();
      chk("t5_err_set", err_o, 1);
      cycle();
      settle();
      chk("t5_err_sticky", err_o, 1);
      cycle();

      // both hosts request continuously with grant always high
      imem_req_i  = 1'b1;
      imem_addr_i = 64'h4;
      dmem_req_i  = 1'b1;
      dmem_addr_i = 64'h5000;
      mem_gnt_i   = 1'b1;
      exp_own     = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = {32'(c + 16), 32'(c * 3)};
         end
         settle();
         if (c > 0) chk_resp(mem_rdata_i);
         chk("t6_dgnt", dmem_gnt_o, exp_own);
         chk("t6_ignt", imem_gnt_o, !exp_own);
         push_exp(exp_own, !exp_own);
`ifdef LUCID_ARB_ROUND_ROBIN_EN
         exp_own = !exp_own;
`endif
         cycle();
      end
      imem_req_i   = 1'b0;
      dmem_req_i   = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h0F0F_F0F0_3C3C_C3C3;
      settle();
      chk_resp(mem_rdata_i);
      cycle();
      idle();
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
